// File: rtl/bk_adder_arbiter.sv
// Round-robin sharing of one 32-bit Brent-Kung adder among NREQ requesters, with
// carry-chained multi-word bursts. Define BK_ARB_SUB_EN to add per-burst subtraction (req_sub).
module bk_adder_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [NREQ*32-1:0]  req_a,
  input  logic [NREQ*32-1:0]  req_b,
  input  logic [NREQ-1:0]     req_cin,
  input  logic [NREQ-1:0]     req_last,
`ifdef BK_ARB_SUB_EN
  input  logic [NREQ-1:0]     req_sub,
`endif
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_sum,
  output logic                out_cout,
  output logic [IDW-1:0]      out_id,
  output logic                out_last,
  output logic                busy
);

  typedef enum logic {ARB = 1'b0, BURST = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  rr_q, rr_d, owner_q, owner_d;
  logic            carry_q, carry_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_sum_q, out_sum_d;
  logic            out_cout_q, out_cout_d;
  logic [IDW-1:0]  out_id_q, out_id_d;
  logic            out_last_q, out_last_d;
`ifdef BK_ARB_SUB_EN
  logic            sub_q, sub_d;
`endif

  logic            gnt_vld, stage_free, xfer, sub_act, cin_eff;
  logic [IDW-1:0]  gnt_id, rr_inc;
  logic [31:0]     a_sel, b_sel, b_eff;
  logic [32:0]     add_res;

  // Brent-Kung prefix: up-sweep builds spans 2,4,..,32; down-sweep fills the gaps.
  function automatic logic [32:0] bk_add(input logic [31:0] a, input logic [31:0] b,
                                         input logic cin);
    logic [31:0] p0, p, g, c;
    p0 = a ^ b;
    p  = p0;
    g  = a & b;
    g[0] = g[0] | (p[0] & cin);
    for (int l = 0; l < 5; l++)
      for (int i = 0; i < 32; i++)
        if ((i + 1) % (2 << l) == 0) begin
          g[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p[i] = p[i] & p[i - (1 << l)];
        end
    for (int l = 3; l >= 0; l--)
      for (int i = 0; i < 32; i++)
        if (((i + 1) % (2 << l) == (1 << l)) && (i >= (2 << l))) begin
          g[i] = g[i] | (p[i] & g[i - (1 << l)]);
          p[i] = p[i] & p[i - (1 << l)];
        end
    c = {g[30:0], cin};
    return {g[31], p0 ^ c};
  endfunction

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    if (state_q == BURST) begin
      gnt_vld = req_valid[owner_q];
      gnt_id  = owner_q;
    end else begin
      // Descending scan so the requester closest to rr_q is written last and wins.
      for (int k = NREQ - 1; k >= 0; k--)
        if (req_valid[(int'(rr_q) + k) % NREQ]) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'((int'(rr_q) + k) % NREQ);
        end
    end
  end

  assign stage_free = ~out_valid_q | out_ready;
  assign xfer       = gnt_vld & stage_free;
  assign req_ready  = xfer ? (NREQ'(1) << gnt_id) : '0;
  assign rr_inc     = IDW'((int'(gnt_id) + 1) % NREQ);

`ifdef BK_ARB_SUB_EN
  assign sub_act = (state_q == BURST) ? sub_q : req_sub[gnt_id];
`else
  assign sub_act = 1'b0;
`endif

  assign a_sel   = req_a[32*gnt_id +: 32];
  assign b_sel   = req_b[32*gnt_id +: 32];
  assign b_eff   = sub_act ? ~b_sel : b_sel;
  assign cin_eff = (state_q == BURST) ? carry_q : (sub_act | req_cin[gnt_id]);
  assign add_res = bk_add(a_sel, b_eff, cin_eff);

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    owner_d     = owner_q;
    carry_d     = carry_q;
    out_valid_d = out_valid_q & ~out_ready;
    out_sum_d   = out_sum_q;
    out_cout_d  = out_cout_q;
    out_id_d    = out_id_q;
    out_last_d  = out_last_q;
`ifdef BK_ARB_SUB_EN
    sub_d       = sub_q;
    if (xfer && state_q == ARB) sub_d = sub_act;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_sum_d   = add_res[31:0];
      out_cout_d  = add_res[32];
      out_id_d    = gnt_id;
      out_last_d  = req_last[gnt_id];
      carry_d     = add_res[32];
      if (req_last[gnt_id]) begin
        state_d = ARB;
        rr_d    = rr_inc;
      end else begin
        state_d = BURST;
        owner_d = gnt_id;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB;
      rr_q        <= '0;
      owner_q     <= '0;
      carry_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_id_q    <= '0;
      out_last_q  <= 1'b0;
`ifdef BK_ARB_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      owner_q     <= owner_d;
      carry_q     <= carry_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_id_q    <= out_id_d;
      out_last_q  <= out_last_d;
`ifdef BK_ARB_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign out_id    = out_id_q;
  assign out_last  = out_last_q;
  assign busy      = (state_q == BURST) | out_valid_q;

endmodule

// File: tb/tb_bk_adder_arbiter.sv
// Bench for bk_adder_arbiter: per-lane word queues drive the requesters, and a
// cycle model built from plain 33-bit addition and round-robin rules checks every cycle.
module tb_bk_adder_arbiter;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  typedef struct packed { logic [31:0] a; logic [31:0] b; logic cin; logic last; } word_t;
  typedef struct packed { logic [IDW-1:0] id; logic [31:0] sum; logic cout; logic last; } res_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0, req_cin = '0, req_last = '0, req_sub = '0;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a = '0, req_b = '0;
  logic out_valid, out_cout, out_last, busy;
  logic out_ready = 1'b1;
  logic [31:0] out_sum;
  logic [IDW-1:0] out_id;

  int checks = 0, failures = 0;
  word_t q[NREQ][$];
  res_t rlog[$];
  logic [NREQ-1:0] pres = '0, fire_q = '0;
  logic ordy_rand = 1'b0, gate_rand = 1'b0;

  // reference model state
  logic m_valid, m_cout, m_last, m_locked, m_carry, m_sub;
  logic [31:0] m_sum;
  int m_id, m_rr, m_owner;

  bk_adder_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_last(req_last),
`ifdef BK_ARB_SUB_EN
    .req_sub(req_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_cout(out_cout), .out_id(out_id), .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input int idx, input int id, input logic [31:0] sum, input logic cout);
    if (idx >= rlog.size()) begin
      checks++;
      failures++;
      $display("FAIL log_missing idx=%0d actual_entries=%0d required_entries>%0d", idx, rlog.size(), idx);
    end else begin
      chk($sformatf("log%0d_id", idx), 64'(rlog[idx].id), 64'(id));
      chk($sformatf("log%0d_sum", idx), 64'(rlog[idx].sum), 64'(sum));
      chk($sformatf("log%0d_cout", idx), 64'(rlog[idx].cout), 64'(cout));
    end
  endtask

  // Model: expected output register, grant and ready, evaluated where inputs are stable.
  always @(negedge clk) begin
    int g;
    logic [NREQ-1:0] exp_rdy;
    logic free, cin, sub;
    logic [31:0] bb;
    logic [32:0] r;
    if (!rst_n) begin
      m_valid = 0; m_sum = '0; m_cout = 0; m_id = 0; m_last = 0;
      m_locked = 0; m_carry = 0; m_sub = 0; m_rr = 0; m_owner = 0;
      fire_q = '0;
    end else begin
      chk("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        chk("out_sum", 64'(out_sum), 64'(m_sum));
        chk("out_cout", 64'(out_cout), 64'(m_cout));
        chk("out_id", 64'(out_id), 64'(m_id));
        chk("out_last", 64'(out_last), 64'(m_last));
      end
      chk("busy", 64'(busy), 64'(m_locked || m_valid));
      free = !m_valid || out_ready;
      g = -1;
      if (m_locked) begin
        if (req_valid[m_owner]) g = m_owner;
      end else begin
        for (int k = 0; k < NREQ; k++)
          if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      end
      exp_rdy = (free && g >= 0) ? (NREQ'(1) << g) : '0;
      chk("req_ready", 64'(req_ready), 64'(exp_rdy));
      fire_q = req_valid & req_ready;
      if (out_valid && out_ready) rlog.push_back({out_id, out_sum, out_cout, out_last});
      if (free && g >= 0) begin
        sub = m_locked ? m_sub : req_sub[g];
        cin = m_locked ? m_carry : (sub | req_cin[g]);
        bb  = req_b[32*g +: 32];
        if (sub) bb = ~bb;
        r = {1'b0, req_a[32*g +: 32]} + {1'b0, bb} + 33'(cin);
        m_valid = 1; m_sum = r[31:0]; m_cout = r[32]; m_id = g; m_last = req_last[g];
        if (req_last[g]) begin
          m_locked = 0;
          m_rr = (g + 1) % NREQ;
        end else begin
          if (!m_locked) begin m_owner = g; m_sub = sub; end
          m_locked = 1;
          m_carry = r[32];
        end
      end else if (out_ready) begin
        m_valid = 0;
      end
    end
  end

  // Lane driver: a presented word stays valid until accepted.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NREQ; i++) begin
      if (fire_q[i] && q[i].size() > 0) begin
        void'(q[i].pop_front());
        pres[i] = 1'b0;
      end
      if (q[i].size() == 0) pres[i] = 1'b0;
      else if (!pres[i] && (!gate_rand || $urandom_range(0, 2) != 0)) pres[i] = 1'b1;
      req_valid[i] = pres[i];
      if (q[i].size() > 0) begin
        req_a[32*i +: 32] = q[i][0].a;
        req_b[32*i +: 32] = q[i][0].b;
        req_cin[i]        = q[i][0].cin;
        req_last[i]       = q[i][0].last;
      end
    end
    fire_q = '0;
    if (ordy_rand) out_ready = ($urandom_range(0, 3) != 0);
  end

  function automatic bit pending();
    bit p = out_valid || (pres != '0);
    for (int i = 0; i < NREQ; i++) if (q[i].size() > 0) p = 1;
    return p;
  endfunction

  task automatic wait_drain(input int maxc);
    int n = 0;
    @(negedge clk);
    while (pending() && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < maxc), 64'(1));
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < NREQ; i++) q[i].delete();
    pres = '0;
    req_valid = '0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    clear_lanes();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  function automatic logic [31:0] rnd_word();
    return ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : 32'($urandom());
  endfunction

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_sum", 64'(out_sum), 64'(0));
    chk("rst_out_id", 64'(out_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    @(posedge clk);
    #2 rst_n = 1'b1;

    // single word on req0
    rlog.delete();
    q[0].push_back('{32'h5, 32'h3, 1'b1, 1'b1});
    wait_drain(50);
    chk_log(0, 0, 32'h9, 1'b0);

    // all four requesters, round-robin order 0,1,2,3,0
    do_reset();
    rlog.delete();
    for (int i = 0; i < NREQ; i++) q[i].push_back('{32'h100 * (i + 1), 32'(i), 1'b0, 1'b1});
    q[0].push_back('{32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1});
    wait_drain(50);
    chk_log(0, 0, 32'h100, 1'b0);
    chk_log(1, 1, 32'h201, 1'b0);
    chk_log(2, 2, 32'h302, 1'b0);
    chk_log(3, 3, 32'h403, 1'b0);
    chk_log(4, 0, 32'h0, 1'b1);

    // two-word burst on req2 while req1 and req3 wait; rr starts at 2
    do_reset();
    q[1].push_back('{32'h1, 32'h1, 1'b0, 1'b1});
    wait_drain(50);
    rlog.delete();
    q[2].push_back('{32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0});
    q[2].push_back('{32'h0, 32'h0, 1'b0, 1'b1});
    q[1].push_back('{32'h2, 32'h2, 1'b0, 1'b1});
    q[3].push_back('{32'h3, 32'h3, 1'b0, 1'b1});
    wait_drain(50);
    chk_log(0, 2, 32'h0, 1'b1);
    chk_log(1, 2, 32'h1, 1'b0);
    chk_log(2, 3, 32'h6, 1'b0);
    chk_log(3, 1, 32'h4, 1'b0);

    // downstream stall with a result pending
    do_reset();
    out_ready = 1'b0;
    q[0].push_back('{32'd10, 32'd20, 1'b0, 1'b1});
    q[1].push_back('{32'd1, 32'd2, 1'b0, 1'b1});
    n = 0;
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("stall_result_seen", 64'(out_valid), 64'(1));
    for (int c = 0; c < 3; c++) begin
      chk("stall_sum", 64'(out_sum), 64'h1E);
      chk("stall_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    @(posedge clk);
    #2 out_ready = 1'b1;
    #1 chk("release_grant", 64'(req_ready), 64'b0010);
    wait_drain(50);

    // randomized bursts, valid gaps and backpressure
    gate_rand = 1'b1;
    ordy_rand = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      for (int b = 0; b < 20; b++) begin
        int len = $urandom_range(1, 4);
        for (int w = 0; w < len; w++)
          q[i].push_back('{rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'(w == len - 1)});
      end
    end
    wait_drain(20000);
    gate_rand = 1'b0;
    ordy_rand = 1'b0;
    out_ready = 1'b1;

    // asynchronous reset in the middle of a burst on req2
    rlog.delete();
    for (int w = 0; w < 4; w++) q[2].push_back('{32'hFFFF_FFFF, 32'h0, 1'b1, 1'(w == 3)});
    n = 0;
    while (rlog.size() < 1 && n < 50) begin @(negedge clk); n++; end
    chk("burst_started", 64'(rlog.size() >= 1), 64'(1));
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_out_valid", 64'(out_valid), 64'(0));
    chk("async_rst_busy", 64'(busy), 64'(0));
    clear_lanes();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    rlog.delete();
    for (int i = 0; i < NREQ; i++) q[i].push_back('{32'(i), 32'(i), 1'b0, 1'b1});
    wait_drain(50);
    chk_log(0, 0, 32'h0, 1'b0);
    chk_log(1, 1, 32'h2, 1'b0);

`ifdef BK_ARB_SUB_EN
    rlog.delete();
    req_sub[0] = 1'b1;
    q[0].push_back('{32'd5, 32'd7, 1'b0, 1'b1});
    q[0].push_back('{32'd7, 32'd5, 1'b0, 1'b1});
    wait_drain(50);
    req_sub = '0;
    chk_log(0, 0, 32'hFFFF_FFFE, 1'b0);
    chk_log(1, 0, 32'h2, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/bk_adder_arbiter.md
Name: bk_adder_arbiter

Overview:
- Shares one 32-bit Brent-Kung prefix adder (bentkung) among NREQ requesters.
- Round-robin arbitration with valid/ready handshakes on every port.
- Supports multi-word (multi-precision) bursts that lock the adder to one requester and chain carry-out to carry-in between words.
- One registered output stage; sits between the Dadda multiplier's reduction/accumulate clients and downstream consumers.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of requester ID; must equal clog2(NREQ).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester operand word valid.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- req_a  input  NREQ*32  operand A; requester i at bits [32*i+31:32*i].
- req_b  input  NREQ*32  operand B, same packing as req_a.
- req_cin  input  NREQ  carry-in; used only on the first word of a burst.
- req_last  input  NREQ  marks the final word of a burst; 1 for single-word ops.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accept.
- out_sum  output  32  adder sum.
- out_cout  output  1  adder carry-out.
- out_id  output  IDW  requester that produced the result.
- out_last  output  1  copy of req_last for this word.
- busy  output  1  high in BURST state or while out_valid=1.

Behaviour:
- Reset values (async, rst_n=0): out_valid=0, out_sum=0, out_cout=0, out_id=0, out_last=0, state=ARB, rr_ptr=0, carry_reg=0, owner=0.
- Stage free: out_valid=0, or out_valid=1 and out_ready=1.
- Grants are issued only when the stage is free.
- A transfer occurs when req_valid[i] and req_ready[i] are both 1.
- req_ready is combinational from req_valid, state, owner, rr_ptr and stage-free.
- Adder operands are muxed from the granted requester; the adder is combinational.
- Result is registered at the accept edge. Latency is 1 cycle; throughput is 1 word/cycle while out_ready=1.
- While out_valid=1 and out_ready=0, all out_* signals hold stable and every req_ready=0.
- ARB state:
  - Grant the first valid requester searching from rr_ptr upward, wrapping modulo NREQ.
  - Carry-in is req_cin[g].
  - On accept with req_last=1: stay in ARB, set rr_ptr=g+1 mod NREQ.
  - On accept with req_last=0: go to BURST, set owner=g, carry_reg=adder cout.
- BURST state:
  - Only the owner can be granted. If the owner drops valid, the adder idles; no other requester is served.
  - Carry-in is carry_reg; req_cin is ignored.
  - On each accept, carry_reg takes the adder cout.
  - Accept with req_last=1 returns to ARB and sets rr_ptr=owner+1 mod NREQ.
- out_cout always reports the raw adder carry of that word.
- No valid requests in ARB: no grant, rr_ptr unchanged.
- Reset asserted mid-burst abandons the burst; the partial result is discarded.
- rr_ptr changes only on burst completion, so a long burst does not cost the next requester its turn.

Optional Feature:
- Macro: BK_ARB_SUB_EN.
- Defined:
  - Adds input port req_sub (NREQ bits).
  - req_sub sampled on the first word of a burst is latched as sub_reg for the whole burst.
  - When active, B is inverted on every word and first-word carry-in is forced to 1, ignoring req_cin. Chained carries are unchanged.
  - out_cout=1 means no borrow.
  - sub_reg resets to 0.
- Not defined: port absent, add only.

Test Plan:
- Reset, then req0 only: a=0x0000_0005, b=0x0000_0003, cin=1, last=1 -> after 1 cycle out_valid=1, out_sum=0x9, out_cout=0, out_id=0.
- All four requesters valid, single-word ops, out_ready=1 -> grants in order 0,1,2,3,0; one result per cycle; out_id follows that order.
- req2 two-word burst: word0 a=0xFFFF_FFFF, b=0x1, last=0; word1 a=0, b=0, last=1; req1 also valid -> results 0x0000_0000/cout=1, then 0x0000_0001/cout=0. req1 is not granted until after word1; next grant goes to req3 if valid, else req1.
- out_ready held 0 for 3 cycles with a result pending -> out_* stable, all req_ready=0; on release, the next grant occurs in the same cycle.
- rst_n asserted asynchronously mid-burst (between edges) -> out_valid=0 immediately; after release, state=ARB and req0 has priority.
- With BK_ARB_SUB_EN: req_sub=1, a=5, b=7, last=1 -> out_sum=0xFFFF_FFFE, out_cout=0. Then a=7, b=5 -> out_sum=0x2, out_cout=1.
